// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one trial subtraction per clock.
// Define SIGNED_DIV_EN for two's-complement operands (adds a FIX cycle).
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SIGNED_DIV_EN
  typedef enum logic [1:0] {IDLE, CALC, DBZ, FIX} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DBZ} state_t;
`endif

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] n_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;
`ifdef SIGNED_DIV_EN
  logic             qneg_q;
  logic             rneg_q;

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x
  );
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction
`endif

  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] sum;
  logic             carry;
  logic [WIDTH:0]   r_d;
  logic [WIDTH-1:0] q_d;

  // Trial subtract as A + ~B + 1; carry-out high means no borrow.
  always_comb begin
    r_sh  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    sum   = {1'b0, r_sh}
          + {1'b0, ~{1'b0, d_q}}
          + (WIDTH+2)'(1);
    carry = sum[WIDTH+1];
    r_d   = carry ? sum[WIDTH:0] : r_sh;
    q_d   = {q_q[WIDTH-2:0], carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
`ifdef SIGNED_DIV_EN
            q_q    <= mag(dividend);
            d_q    <= mag(divisor);
            qneg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_q <= dividend[WIDTH-1];
`else
            q_q    <= dividend;
            d_q    <= divisor;
`endif
            n_q    <= dividend;
            r_q    <= '0;
            cnt_q  <= CW'(WIDTH);
            busy_q <= 1'b1;
            state_q <= (divisor == '0) ? DBZ : CALC;
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
`ifdef SIGNED_DIV_EN
            state_q <= FIX;
`else
            quo_q   <= q_d;
            rem_q   <= r_d[WIDTH-1:0];
            dbz_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`endif
          end
        end
        DBZ: begin
          quo_q   <= '1;
          rem_q   <= n_q;
          dbz_q   <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
`ifdef SIGNED_DIV_EN
        FIX: begin
          quo_q   <= qneg_q ? (~q_q + WIDTH'(1)) : q_q;
          rem_q   <= rneg_q ? (~r_q[WIDTH-1:0] + WIDTH'(1))
                            : r_q[WIDTH-1:0];
          dbz_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (WIDTH=4).
// Covers both the unsigned build and SIGNED_DIV_EN.
module tb_seq_restoring_divider;

  localparam int W = 4;
`ifdef SIGNED_DIV_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    exp_t e;
    logic [W-1:0] ma, mb;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
      return e;
    end
`ifdef SIGNED_DIV_EN
    ma = a[W-1] ? (~a + W'(1)) : a;
    mb = b[W-1] ? (~b + W'(1)) : b;
    e.q = ma / mb;
    e.r = ma % mb;
    if (a[W-1] ^ b[W-1]) e.q = ~e.q + W'(1);
    if (a[W-1]) e.r = ~e.r + W'(1);
`else
    ma = a;
    mb = b;
    e.q = ma / mb;
    e.r = ma % mb;
`endif
    e.z = 1'b0;
    return e;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  // Called at a negedge with busy low; returns at the negedge after the accept edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0)
      $display("FAIL reset_state got=%b want=0",
               {busy, done, quotient, remainder, div_by_zero});
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    exp_t e;
    accept(a, b);
    total++;
    if (busy !== 1'b1)
      $display("FAIL busy_after_accept %0d/%0d got=%b want=1", a, b, busy);
    else passed++;
    wait_done(n);
    e = pop_exp();
    total++;
    if ({quotient, remainder, div_by_zero} !== e || n != LAT)
      $display("FAIL result %0d/%0d got q=%b r=%b z=%b lat=%0d want q=%b r=%b z=%b lat=%0d",
               a, b, quotient, remainder, div_by_zero, n, e.q, e.r, e.z, LAT);
    else passed++;
    @(negedge clk);
    total++;
    if (done !== 1'b0)
      $display("FAIL done_pulse %0d/%0d got=%b want=0", a, b, done);
    else passed++;
  endtask

  task automatic test_boundaries();
    logic [W-1:0] a, b;
    test_basic(4'd2, 4'd9);
    test_basic(4'd0, 4'd5);
    test_basic(4'd11, 4'd1);
    test_basic(4'd15, 4'd15);
    for (int i = 0; i < 6; i++) begin
      a = W'($urandom_range(0, 15));
      b = W'($urandom_range(1, 15));
      test_basic(a, b);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    exp_t e;
    start    = 1'b1;
    dividend = 4'd15;
    divisor  = 4'd1;
    sb.push_back(model(4'd15, 4'd1));
    @(negedge clk);
    dividend = 4'd3;
    divisor  = 4'd7;
    sb.push_back(model(4'd3, 4'd7));
    wait_done(n);
    e = pop_exp();
    total++;
    if ({quotient, remainder, div_by_zero} !== e || n != LAT || busy !== 1'b0)
      $display("FAIL b2b_first got q=%b r=%b z=%b lat=%0d busy=%b want q=%b r=%b z=%b lat=%0d busy=0",
               quotient, remainder, div_by_zero, n, busy, e.q, e.r, e.z, LAT);
    else passed++;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", busy, done);
    else passed++;
    wait_done(n);
    e = pop_exp();
    total++;
    if ({quotient, remainder, div_by_zero} !== e || n != LAT)
      $display("FAIL b2b_second got q=%b r=%b z=%b lat=%0d want q=%b r=%b z=%b lat=%0d",
               quotient, remainder, div_by_zero, n, e.q, e.r, e.z, LAT);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_dbz();
    int n;
    exp_t e;
    accept(4'd5, 4'd0);
    wait_done(n);
    e = pop_exp();
    total++;
    if ({quotient, remainder, div_by_zero} !== e || n != 1)
      $display("FAIL dbz got q=%b r=%b z=%b lat=%0d want q=%b r=%b z=%b lat=1",
               quotient, remainder, div_by_zero, n, e.q, e.r, e.z);
    else passed++;
    accept(4'd9, 4'd2);
    wait_done(n);
    e = pop_exp();
    total++;
    if ({quotient, remainder, div_by_zero} !== e || n != LAT)
      $display("FAIL dbz_clear got q=%b r=%b z=%b lat=%0d want q=%b r=%b z=%b lat=%0d",
               quotient, remainder, div_by_zero, n, e.q, e.r, e.z, LAT);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int n;
    exp_t e;
    accept(4'd12, 4'd5);
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd1;
    divisor  = 4'd1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL ignore_busy got busy=%b done=%b want busy=1 done=0", busy, done);
    else passed++;
    wait_done(n);
    e = pop_exp();
    total++;
    if ({quotient, remainder, div_by_zero} !== e || n + 2 != LAT || sb.size() != 0)
      $display("FAIL ignore_result got q=%b r=%b z=%b lat=%0d want q=%b r=%b z=%b lat=%0d",
               quotient, remainder, div_by_zero, n + 2, e.q, e.r, e.z, LAT);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    int dones;
    exp_t e;
    accept(4'd14, 4'd3);
    void'(sb.pop_back());
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0)
      $display("FAIL reset_mid got=%b want=0",
               {busy, done, quotient, remainder, div_by_zero});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    total++;
    if (dones != 0)
      $display("FAIL reset_abandon got=%0d active cycles want=0", dones);
    else passed++;
    accept(4'd6, 4'd2);
    wait_done(n);
    e = pop_exp();
    total++;
    if ({quotient, remainder, div_by_zero} !== e || n != LAT)
      $display("FAIL reset_next got q=%b r=%b z=%b lat=%0d want q=%b r=%b z=%b lat=%0d",
               quotient, remainder, div_by_zero, n, e.q, e.r, e.z, LAT);
    else passed++;
    @(negedge clk);
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed();
    test_basic(4'b1001, 4'b0010);
    test_basic(4'b0111, 4'b1110);
    test_basic(4'b1000, 4'b1111);
    test_basic(4'b1010, 4'b1101);
  endtask
`endif

  initial begin
    test_reset();
    test_basic(4'd13, 4'd3);
    test_back_to_back();
    test_dbz();
    test_ignore_busy();
    test_reset_mid();
    test_boundaries();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
